// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver and its FIFO.
package uart_pkg;

   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

   typedef enum logic [2:0] {INIT, IDLE, START, DATA, PARITY, STOP} rx_state_t;

   // Bits needed to index `value` entries; never returns less than 1.
   function automatic int unsigned clog2s(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < value) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO holding received characters with their error flags.
module rx_fifo import uart_pkg::*; #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = clog2s(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
   always_comb begin
      empty_o = (count_q == '0);
      full_o  = (count_q == (AW+1)'(DEPTH));
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      rdata_o = mem_q[rptr_q];
      count_o = count_q;
   end

   // Storage array; contents are only observed while non-empty, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote, error flags, break detect and receive FIFO.
module uart_rx_fifo import uart_pkg::*; #(
   parameter int unsigned CLK_FREQUENCY = 100_000_000,
   parameter int unsigned BAUD_RATE     = 19_200,
   parameter int unsigned OVERSAMPLE    = 16,
   parameter int unsigned DATA_BITS     = 8,
   parameter parity_t     PARITY_MODE   = PAR_ODD,
   parameter int unsigned STOP_BITS     = 1,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 Sin,
   input  logic                 ReceiveAck,
   input  logic                 ClrOverrun,
   output logic [DATA_BITS-1:0] Dout,
   output logic                 Receive,
   output logic                 parityErr,
   output logic                 frameErr,
   output logic                 overrun,
   output logic                 breakDet,
   output logic                 rxBusy
);

   localparam int unsigned DIV = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned DW  = clog2s(DIV);
   localparam int unsigned SW  = clog2s(OVERSAMPLE);
   localparam int unsigned BW  = clog2s(DATA_BITS);
   localparam int unsigned M   = OVERSAMPLE / 2;
   localparam int unsigned EW  = DATA_BITS + 2;
   localparam int unsigned CW  = clog2s(FIFO_DEPTH) + 1;

   logic [1:0]           rst_sync_q;
   logic                 rst_int_n;
   logic                 sync1_q, sync2_q, sync3_q;
   logic [DW-1:0]        div_q;
   logic [SW-1:0]        samp_q;
   logic                 tick;
   logic                 v0_q, v1_q;
   logic                 dec_valid, dec_bit;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bit_q, perr_q, ferr_q;
   logic [BW-1:0]        bcnt_q;
   rx_state_t            state_q, state_d;
   logic                 fall, restart, last_data, last_stop, is_break, push, break_q;
   logic                 parity_bad, ferr_now, overrun_q;
   logic [EW-1:0]        fifo_wdata, fifo_rdata;
   logic                 fifo_full, fifo_empty, fifo_pop;
   logic [CW-1:0]        fifo_count;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end
   assign rst_int_n = rst_sync_q[1];

   // Two-flop synchroniser plus one extra stage for falling-edge detection.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         sync3_q <= 1'b1;
      end else begin
         sync1_q <= Sin;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign tick = (div_q == DW'(DIV - 1));
   assign fall = sync3_q && !sync2_q;

   // Tick divider and per-bit sample counter, realigned to a start edge.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         div_q  <= '0;
         samp_q <= '0;
      end else if (restart) begin
         div_q  <= '0;
         samp_q <= '0;
      end else if (tick) begin
         div_q  <= '0;
         samp_q <= (samp_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_q + SW'(1);
      end else begin
         div_q <= div_q + DW'(1);
      end
   end

   // Capture samples M-1 and M; the third vote is the live sample at M+1.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         v0_q <= 1'b1;
         v1_q <= 1'b1;
      end else if (tick) begin
         if (samp_q == SW'(M - 1)) v0_q <= sync2_q;
         if (samp_q == SW'(M))     v1_q <= sync2_q;
      end
   end

   assign dec_valid  = tick && (samp_q == SW'(M + 1));
   assign dec_bit    = (v0_q & v1_q) | (v0_q & sync2_q) | (v1_q & sync2_q);
   assign last_data  = (bcnt_q == BW'(DATA_BITS - 1));
   assign last_stop  = (bcnt_q == BW'(STOP_BITS - 1));
   assign parity_bad = ((^shift_q) ^ dec_bit) != (PARITY_MODE == PAR_ODD);
   assign ferr_now   = ferr_q || !dec_bit;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT:   if (tick && sync2_q) state_d = IDLE;
         IDLE:   if (fall) state_d = START;
         START:  if (dec_valid) state_d = dec_bit ? IDLE : DATA;
         DATA:   if (dec_valid && last_data) begin
                    state_d = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                 end
         PARITY: if (dec_valid) state_d = STOP;
         STOP:   if (is_break) begin
                    state_d = INIT;
                 end else if (dec_valid && last_stop) begin
                    state_d = ferr_now ? INIT : IDLE;
                 end
         default: state_d = INIT;
      endcase
   end

   // FSM outputs: realign, break and push strobes, busy flag.
   always_comb begin
      restart  = (state_q == IDLE) && fall;
      is_break = dec_valid && (state_q == STOP) && (bcnt_q == '0) && !dec_bit &&
                 (shift_q == '0) && !par_bit_q;
      push     = dec_valid && (state_q == STOP) && last_stop && !is_break;
      rxBusy   = (state_q != IDLE) && (state_q != INIT);
   end

   // Character datapath: shift register, parity/stop flags, bit counter.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         shift_q   <= '0;
         par_bit_q <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         bcnt_q    <= '0;
      end else if (restart) begin
         par_bit_q <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         bcnt_q    <= '0;
      end else if (dec_valid) begin
         case (state_q)
            DATA: begin
               shift_q <= {dec_bit, shift_q[DATA_BITS-1:1]};
               bcnt_q  <= last_data ? '0 : bcnt_q + BW'(1);
            end
            PARITY: begin
               par_bit_q <= dec_bit;
               perr_q    <= parity_bad;
            end
            STOP: begin
               if (!dec_bit) ferr_q <= 1'b1;
               bcnt_q <= bcnt_q + BW'(1);
            end
            default: ;
         endcase
      end
   end

   // Break pulse and sticky overrun; a drop beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         break_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         break_q <= is_break;
         if (push && fifo_full && !fifo_pop) begin
            overrun_q <= 1'b1;
         end else if (ClrOverrun) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign fifo_wdata = {shift_q, perr_q, ferr_now};
   assign fifo_pop   = ReceiveAck && Receive;

   rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .push_i  (push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Head entry is forced to zero while empty so stale data never shows.
   always_comb begin
      Receive   = (fifo_count != '0);
      Dout      = fifo_empty ? '0 : fifo_rdata[EW-1:2];
      parityErr = fifo_empty ? 1'b0 : fifo_rdata[1];
      frameErr  = fifo_empty ? 1'b0 : fifo_rdata[0];
      overrun   = overrun_q;
      breakDet  = break_q;
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: 160 clocks per bit, 8 data bits, odd parity, 1 stop.
module tb_uart_rx_fifo;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       Sin;
   logic       ReceiveAck;
   logic       ClrOverrun;
   logic [7:0] Dout;
   logic       Receive, parityErr, frameErr, overrun, breakDet, rxBusy;

   int errors = 0;
   int checks = 0;

   uart_rx_fifo #(
      .CLK_FREQUENCY (1_600_000),
      .BAUD_RATE     (10_000),
      .OVERSAMPLE    (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Sin        (Sin),
      .ReceiveAck (ReceiveAck),
      .ClrOverrun (ClrOverrun),
      .Dout       (Dout),
      .Receive    (Receive),
      .parityErr  (parityErr),
      .frameErr   (frameErr),
      .overrun    (overrun),
      .breakDet   (breakDet),
      .rxBusy     (rxBusy)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Odd parity: total count of ones over data plus parity bit must be odd.
   function automatic logic model_perr(input logic [7:0] d, input logic p);
      int ones;
      ones = p;
      for (int i = 0; i < 8; i++) ones += d[i];
      return (ones % 2) != 1;
   endfunction

   // Sends frame bits [0..nbits-1] (start, data LSB first, parity, stop);
   // optionally inverts one bit for a window covering only its middle sample.
   task automatic send_char(input logic [7:0] d, input logic p, input logic s,
                            input int glitch_idx, input int nbits);
      logic [10:0] fr;
      fr = {s, p, d, 1'b0};
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < 160; c++) begin
            Sin = (b == glitch_idx && c >= 86 && c < 95) ? ~fr[b] : fr[b];
            @(negedge clk);
         end
      end
      Sin = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_rx(input string name);
      int n;
      n = 0;
      while (!Receive && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, Receive}, 32'd1);
   endtask

   task automatic pop_check(input string name, input logic [7:0] d, input logic pe,
                            input logic fe);
      check({name, "_dout"}, {24'd0, Dout}, {24'd0, d});
      check({name, "_perr"}, {31'd0, parityErr}, {31'd0, pe});
      check({name, "_ferr"}, {31'd0, frameErr}, {31'd0, fe});
      ReceiveAck = 1'b1;
      @(negedge clk);
      ReceiveAck = 1'b0;
   endtask

   vec_t       vecs [7];
   logic [7:0] exp_q [$];
   logic [7:0] rd, ed;
   logic       rp, rs, exp_ovr;
   int         pulses, leaked;

   initial begin
      vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{8'h37, 1'b0, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0; Sin = 1'b1; ReceiveAck = 1'b0; ClrOverrun = 1'b0;
      idle(3);
      check("rst_receive", {31'd0, Receive}, 32'd0);
      check("rst_dout", {24'd0, Dout}, 32'd0);
      check("rst_flags", {28'd0, parityErr, frameErr, overrun, breakDet}, 32'd0);
      check("rst_busy", {31'd0, rxBusy}, 32'd0);
      rst_n = 1'b1;
      idle(40);

      // Receive timing around the stop-bit decision, then single pop.
      send_char(8'h5A, 1'b1, 1'b1, -1, 10);
      Sin = 1'b1;
      idle(95);
      check("t1_before_decision", {31'd0, Receive}, 32'd0);
      idle(15);
      check("t1_after_decision", {31'd0, Receive}, 32'd1);
      idle(50);
      pop_check("t1", 8'h5A, 1'b0, 1'b0);
      check("t1_popped", {31'd0, Receive}, 32'd0);
      idle(20);

      // Table of characters with hand-derived flags.
      for (int i = 0; i < 7; i++) begin
         send_char(vecs[i].data, vecs[i].par, vecs[i].stop, -1, 11);
         idle(40);
         wait_rx($sformatf("vec%0d_rx", i));
         pop_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
         check($sformatf("vec%0d_empty", i), {31'd0, Receive}, 32'd0);
      end

      // False start: 40 low clocks are gone before the mid-bit vote.
      Sin = 1'b0;
      idle(40);
      Sin = 1'b1;
      idle(10);
      check("fs_busy_during", {31'd0, rxBusy}, 32'd1);
      idle(200);
      check("fs_busy_after", {31'd0, rxBusy}, 32'd0);
      check("fs_receive", {31'd0, Receive}, 32'd0);
      check("fs_flags", {30'd0, overrun, breakDet}, 32'd0);

      // Middle-sample glitches on a 0 bit and on a 1 bit are voted out.
      send_char(8'hC3, 1'b1, 1'b1, 3, 11);
      idle(40);
      wait_rx("glitch0_rx");
      pop_check("glitch0", 8'hC3, 1'b0, 1'b0);
      send_char(8'hC3, 1'b1, 1'b1, 1, 11);
      idle(40);
      wait_rx("glitch1_rx");
      pop_check("glitch1", 8'hC3, 1'b0, 1'b0);

      // Acks while empty are ignored.
      ReceiveAck = 1'b1;
      idle(3);
      ReceiveAck = 1'b0;
      idle(2);
      check("ack_empty", {31'd0, Receive}, 32'd0);

      // Back-to-back burst of five into a four-deep FIFO.
      exp_ovr = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         ed = 8'h11 + 8'(i);
         send_char(ed, ~^ed, 1'b1, -1, 11);
         if (exp_q.size() < 4) exp_q.push_back(ed);
         else exp_ovr = 1'b1;
      end
      idle(20);
      check("burst_overrun", {31'd0, overrun}, {31'd0, exp_ovr});
      while (exp_q.size() > 0) begin
         ed = exp_q.pop_front();
         check("burst_receive", {31'd0, Receive}, 32'd1);
         pop_check("burst", ed, 1'b0, 1'b0);
      end
      check("burst_drained", {31'd0, Receive}, 32'd0);
      check("burst_overrun_sticky", {31'd0, overrun}, 32'd1);
      ClrOverrun = 1'b1;
      @(negedge clk);
      ClrOverrun = 1'b0;
      check("burst_overrun_clr", {31'd0, overrun}, 32'd0);

      // Randomised characters against the parity/framing model.
      for (int i = 0; i < 8; i++) begin
         rd = 8'($urandom_range(0, 255));
         rp = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 3) != 0);
         if (!rs && rd == 8'h00 && !rp) rd = 8'h01;
         send_char(rd, rp, rs, -1, 11);
         idle(40);
         wait_rx($sformatf("rnd%0d_rx", i));
         pop_check($sformatf("rnd%0d", i), rd, model_perr(rd, rp), !rs);
      end

      // Line break: 12 bit times low.
      pulses = 0;
      leaked = 0;
      Sin = 1'b0;
      for (int c = 0; c < 1920; c++) begin
         @(negedge clk);
         if (breakDet) pulses++;
         if (Receive) leaked++;
      end
      Sin = 1'b1;
      idle(40);
      check("break_pulse_cycles", pulses, 32'd1);
      check("break_no_push", leaked, 32'd0);
      check("break_receive", {31'd0, Receive}, 32'd0);

      // Reset mid-character with an entry waiting in the FIFO.
      send_char(8'h42, 1'b1, 1'b1, -1, 11);
      idle(40);
      wait_rx("rst_pre_rx");
      send_char(8'hFF, 1'b1, 1'b1, -1, 4);
      Sin = 1'b1;
      check("rst_pre_busy", {31'd0, rxBusy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_receive", {31'd0, Receive}, 32'd0);
      check("rst_async_busy", {31'd0, rxBusy}, 32'd0);
      check("rst_async_dout", {24'd0, Dout}, 32'd0);
      idle(3);
      rst_n = 1'b1;
      idle(40);
      send_char(8'hA5, 1'b1, 1'b1, -1, 11);
      idle(40);
      wait_rx("post_rst_rx");
      pop_check("post_rst", 8'hA5, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
